// File: rtl/bank_req_queue.sv
// Per-bank request FIFO feeding the Arbiter; first-word fall-through head on Data_out.
// Latency: push visible on Req/Data_out one cycle after the accepting edge; pop advances head in one cycle.
// Backpressure: In_ready drops at full (no Ack-to-In_ready path); Ack on an empty queue is ignored and flagged.
module bank_req_queue #(
  parameter int REQ_SIZE = 32,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     In_valid,
  input  logic [REQ_SIZE-1:0]      In_data,
  output logic                     In_ready,
  output logic                     Req,
  output logic                     Valid,
  output logic [REQ_SIZE-1:0]      Data_out,
  input  logic                     Ack,
  output logic [$clog2(DEPTH):0]   Count,
  output logic                     Almost_full,
  output logic                     Ack_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AF_CNT   = (AW + 1)'(AF_LEVEL);

  logic [REQ_SIZE-1:0] mem [DEPTH];
  logic [AW-1:0]       wp;
  logic [AW-1:0]       rp;
  logic [AW:0]         cnt;
  logic                push;
  logic                pop;

  // Handshake decode and status outputs; In_ready depends only on registered occupancy.
  always_comb begin
    In_ready    = (cnt != FULL_CNT);
    Req         = (cnt != '0);
    Valid       = Req;
    Data_out    = mem[rp];
    Count       = cnt;
    Almost_full = (cnt >= AF_CNT);
    push        = In_valid && In_ready;
    pop         = Ack && Req;
  end

  // Storage write; contents survive reset, only pointers are cleared.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wp] <= In_data;
    end
  end

  // Pointer and occupancy tracking; reset discards any same-cycle push or pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
      if (push && !pop) begin
        cnt <= cnt + 1'b1;
      end else if (pop && !push) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Sticky protocol-error flag: Arbiter granted this bank while it had nothing queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      Ack_err <= 1'b0;
    end else if (Ack && !Req) begin
      Ack_err <= 1'b1;
    end
  end

endmodule
